// File: rtl/gpr_bank_pkg.sv
// gpr_bank_pkg: default widths and bus FSM state encoding shared by the register bank
package gpr_bank_pkg;
  localparam int DATA_WIDTH_D = 16;
  localparam int ADDR_WIDTH_D = 3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/gpr_bank_bus_fsm.sv
// gpr_bus_fsm: cs/read/rdy bus handshake that captures a request and sequences one register access
module gpr_bus_fsm
  import gpr_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] bus_wd,
  input  logic                  stall,
  output logic                  rdy,
  output logic                  ack,
  output logic                  bus_rd_en,
  output logic                  bus_wr_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata
);
  logic [2:0]            r_state;
  logic                  r_read;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            w_next;
  // next state: a bus write waits in WR for as long as the direct port is writing
  always_comb begin
    w_next = (r_state == S_IDLE) ? (cs ? S_CAPT : S_IDLE) :
             (r_state == S_CAPT) ? (r_read ? S_RD : S_WR) :
             (r_state == S_RD)   ? S_DONE :
             (r_state == S_WR)   ? (stall ? S_WR : S_DONE) : S_IDLE;
  end
  // state register plus request capture, taken only when idle so cs elsewhere is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cs) begin
        r_read  <= read;
        r_addr  <= address;
        r_wdata <= bus_wd;
      end
    end
  end
  assign rdy       = (r_state == S_IDLE);
  assign ack       = (r_state == S_DONE);
  assign bus_rd_en = (r_state == S_RD);
  assign bus_wr_en = (r_state == S_WR) && !stall;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: register file with two registered read ports, a priority direct write port and a bus port
module gpr_bank
  import gpr_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  cs,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] bus_wd,
  output logic [DATA_WIDTH-1:0] bus_rd,
  output logic                  rdy,
  output logic                  ack
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_bus_rd_en;
  logic                  w_bus_wr_en;
  logic [ADDR_WIDTH-1:0] w_bus_addr;
  logic [DATA_WIDTH-1:0] w_bus_wdata;
  logic [DATA_WIDTH-1:0] w_ra;
  logic [DATA_WIDTH-1:0] w_rb;
  logic [DATA_WIDTH-1:0] w_bus_q;
  logic                  w_we_ok;
  logic                  w_bus_ok;
  gpr_bus_fsm #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .read     (read),
    .address  (address),
    .bus_wd   (bus_wd),
    .stall    (we),
    .rdy      (rdy),
    .ack      (ack),
    .bus_rd_en(w_bus_rd_en),
    .bus_wr_en(w_bus_wr_en),
    .bus_addr (w_bus_addr),
    .bus_wdata(w_bus_wdata)
  );
  // read muxes: hardwired zero beats bypass; the bus read path never bypasses
  always_comb begin
    w_we_ok  = we && !(ZERO_REG != 0 && waddr == '0);
    w_bus_ok = w_bus_wr_en && !(ZERO_REG != 0 && w_bus_addr == '0);
    w_ra     = (ZERO_REG != 0 && ra_addr == '0) ? '0 :
               (BYPASS != 0 && we && waddr == ra_addr) ? wdata : r_mem[ra_addr];
    w_rb     = (ZERO_REG != 0 && rb_addr == '0) ? '0 :
               (BYPASS != 0 && we && waddr == rb_addr) ? wdata : r_mem[rb_addr];
    w_bus_q  = (ZERO_REG != 0 && w_bus_addr == '0) ? '0 : r_mem[w_bus_addr];
  end
  // storage: the direct port always wins over a bus commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we_ok) begin
      r_mem[waddr] <= wdata;
    end else if (w_bus_ok) begin
      r_mem[w_bus_addr] <= w_bus_wdata;
    end
  end
  // registered read outputs; bus_rd only updates when a bus read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_data <= '0;
      rb_data <= '0;
      bus_rd  <= '0;
    end else begin
      ra_data <= w_ra;
      rb_data <= w_rb;
      if (w_bus_rd_en) bus_rd <= w_bus_q;
    end
  end
endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: table-driven and scoreboarded checks of two bank configurations driven in parallel
module tb_gpr_bank;
  logic        clk = 1'b0;
  logic        rst, we, cs, read;
  logic [2:0]  ra_addr, rb_addr, waddr, address;
  logic [15:0] wdata, bus_wd;
  logic [15:0] ra_a, rb_a, brd_a, ra_b, rb_b, brd_b;
  logic        rdy_a, ack_a, rdy_b, ack_b;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] ma [8];
  logic [15:0] mb [8];
  typedef struct {
    logic we; logic [2:0] wa; logic [15:0] wd; logic [2:0] ra; logic [2:0] rb;
    logic [15:0] ara; logic [15:0] arb; logic [15:0] bra; logic [15:0] brb;
  } vec_t;
  typedef struct {logic [15:0] ara; logic [15:0] arb; logic [15:0] bra; logic [15:0] brb;} exp_t;
  exp_t q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  gpr_bank #(.ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .ra_data(ra_a), .rb_addr(rb_addr), .rb_data(rb_a),
    .we(we), .waddr(waddr), .wdata(wdata), .cs(cs), .read(read), .address(address),
    .bus_wd(bus_wd), .bus_rd(brd_a), .rdy(rdy_a), .ack(ack_a));
  gpr_bank #(.ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .ra_data(ra_b), .rb_addr(rb_addr), .rb_data(rb_b),
    .we(we), .waddr(waddr), .wdata(wdata), .cs(cs), .read(read), .address(address),
    .bus_wd(bus_wd), .bus_rd(brd_b), .rdy(rdy_b), .ack(ack_b));

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mwrite(input logic [2:0] a, input logic [15:0] d);
    ma[a] = d;
    if (a != 3'd0) mb[a] = d;
  endtask

  task automatic mclear();
    for (int i = 0; i < 8; i++) begin
      ma[i] = 16'h0;
      mb[i] = 16'h0;
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    e = q.pop_front();
    check({nm, "_ra_a"}, ra_a, e.ara);
    check({nm, "_rb_a"}, rb_a, e.arb);
    check({nm, "_ra_b"}, ra_b, e.bra);
    check({nm, "_rb_b"}, rb_b, e.brb);
  endtask

  task automatic cyc(input vec_t v);
    we = v.we; waddr = v.wa; wdata = v.wd; ra_addr = v.ra; rb_addr = v.rb;
    q.push_back('{v.ara, v.arb, v.bra, v.brb});
    tick();
    if (v.we) mwrite(v.wa, v.wd);
    pop_check("vec");
  endtask

  task automatic rd(input logic [2:0] ra, input logic [2:0] rb);
    we = 1'b0; ra_addr = ra; rb_addr = rb;
    q.push_back('{ma[ra], ma[rb], (ra == 3'd0) ? 16'h0 : mb[ra], (rb == 3'd0) ? 16'h0 : mb[rb]});
    tick();
    pop_check("rd");
  endtask

  task automatic bus_op(input logic rd_op, input logic [2:0] a, input logic [15:0] d,
                        input int stall, input logic [2:0] swa, input logic [15:0] swd,
                        input int exp_lat);
    int lat;
    cs = 1'b1; read = rd_op; address = a; bus_wd = d; we = 1'b0;
    tick();
    cs = 1'b0;
    lat = 1;
    check("rdy_busy", 16'(rdy_a), 16'h0);
    while (!ack_a && lat < 30) begin
      we = (lat >= 2 && lat < 2 + stall); waddr = swa; wdata = swd;
      tick();
      if (we) mwrite(swa, swd);
      lat++;
    end
    we = 1'b0;
    check("ack_latency", 16'(lat), 16'(exp_lat));
    check("ack_b", 16'(ack_b), 16'h1);
    check("rdy_done", 16'(rdy_a), 16'h0);
    if (!rd_op) mwrite(a, d);
    tick();
    check("ack_pulse", 16'(ack_a), 16'h0);
    check("rdy_back", 16'(rdy_b), 16'h1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd4, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'hFFFF, 16'hBEEF, 16'h0000, 16'hBEEF};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 3'd7, 16'h0A5A, 3'd7, 3'd7, 16'h0A5A, 16'h0A5A, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 3'd1, 16'h1111, 3'd7, 3'd1, 16'h0A5A, 16'h1111, 16'h0A5A, 16'h0000};
    tbl[6] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 16'h1111, 16'h0000, 16'h1111, 16'h0000};
    tbl[7] = '{1'b1, 3'd6, 16'h6666, 3'd5, 3'd0, 16'hBEEF, 16'hFFFF, 16'hBEEF, 16'h0000};
    tbl[8] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 16'h6666, 16'h0A5A, 16'h6666, 16'h0A5A};
    rst = 1'b1; we = 1'b0; cs = 1'b0; read = 1'b0;
    ra_addr = '0; rb_addr = '0; waddr = '0; address = '0; wdata = '0; bus_wd = '0;
    mclear();
    tick();
    tick();
    rst = 1'b0;
    check("rst_rdy_a", 16'(rdy_a), 16'h1);
    check("rst_ack_a", 16'(ack_a), 16'h0);
    check("rst_rdy_b", 16'(rdy_b), 16'h1);
    check("rst_ack_b", 16'(ack_b), 16'h0);
    check("rst_bus_rd", brd_a, 16'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
    for (int i = 0; i < 9; i++) cyc(tbl[i]);
    bus_op(1'b0, 3'd2, 16'h1234, 0, 3'd0, 16'h0, 3);
    bus_op(1'b1, 3'd2, 16'h0000, 0, 3'd0, 16'h0, 3);
    check("bus_rd_a", brd_a, 16'h1234);
    check("bus_rd_b", brd_b, 16'h1234);
    bus_op(1'b0, 3'd3, 16'h3333, 2, 3'd4, 16'h4444, 5);
    rd(3'd3, 3'd4);
    check("bus_rd_hold", brd_a, 16'h1234);
    bus_op(1'b0, 3'd3, 16'hC3C3, 2, 3'd3, 16'h7777, 5);
    rd(3'd3, 3'd2);
    bus_op(1'b0, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0, 3);
    bus_op(1'b1, 3'd0, 16'h0000, 0, 3'd0, 16'h0, 3);
    check("bus_rd0_a", brd_a, 16'hFFFF);
    check("bus_rd0_b", brd_b, 16'h0000);
    rd(3'd0, 3'd0);
    cs = 1'b1; read = 1'b0; address = 3'd6; bus_wd = 16'hDEAD;
    tick();
    cs = 1'b0;
    tick();
    we = 1'b1; waddr = 3'd2; wdata = 16'h2222;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0;
    mclear();
    check("rst_wr_rdy_a", 16'(rdy_a), 16'h1);
    check("rst_wr_ack_a", 16'(ack_a), 16'h0);
    check("rst_wr_rdy_b", 16'(rdy_b), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_wr_no_ack", 16'(ack_a | ack_b), 16'h0);
    end
    rd(3'd6, 3'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
